// File: rtl/sv32_pma_gate.sv
// sv32_pma_gate: physical memory attribute gate between the Sv32 MMU (34-bit
// physical requests) and the 32-bit system bus. Each request is registered,
// checked against the ROM/IO/RAM regions and either issued on the bus or
// turned into a RISC-V access fault (mcause 1/5/7).
// Ports: clk, reset (sync, active-high); MMU side up_valid/up_ready,
// up_wstrb, up_addr[33:0], up_wdata, up_rdata, is_instruction; bus side
// mem_valid/mem_ready, mem_wstrb, mem_addr, mem_wdata, mem_rdata; fault side
// access_fault, fault_cause, fault_address.
// Optional macro PMA_TIMEOUT_EN: bus watchdog of TIMEOUT_CYCLES in ISSUE.
module sv32_pma_gate #(
    parameter logic [31:0] RAM_BASE       = 32'h8000_0000,
    parameter logic [31:0] RAM_SIZE       = 32'h0400_0000,
    parameter logic [31:0] ROM_BASE       = 32'h0001_0000,
    parameter logic [31:0] ROM_SIZE       = 32'h0001_0000,
    parameter logic [31:0] IO_BASE        = 32'h1000_0000,
    parameter logic [31:0] IO_SIZE        = 32'h1000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic [3:0]  up_wstrb,
    input  logic [33:0] up_addr,
    input  logic [31:0] up_wdata,
    output logic [31:0] up_rdata,
    input  logic        is_instruction,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        access_fault,
    output logic [3:0]  fault_cause,
    output logic [33:0] fault_address
);

    if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
        $error("sv32_pma_gate: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_RESP,
        S_FAULT,
        S_WAIT_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [33:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  cause_q, cause_d;
    logic [33:0] faddr_q, faddr_d;

`ifdef PMA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Region decode on the low 32 bits; overlap resolved ROM > IO > RAM.
    logic rom_hit, io_hit, ram_hit;
    logic sel_rom, sel_io, any_hit;
    logic is_write, chk_fault;
    logic [3:0] cause_calc;

    always_comb begin
        rom_hit  = (addr_q[31:0] & ~(ROM_SIZE - 32'd1)) == ROM_BASE;
        io_hit   = (addr_q[31:0] & ~(IO_SIZE - 32'd1)) == IO_BASE;
        ram_hit  = (addr_q[31:0] & ~(RAM_SIZE - 32'd1)) == RAM_BASE;
        sel_rom  = rom_hit;
        sel_io   = io_hit & ~rom_hit;
        any_hit  = rom_hit | io_hit | ram_hit;
        is_write = |wstrb_q;
        chk_fault = (|addr_q[33:32])
                  | ~any_hit
                  | (instr_q & sel_io)
                  | (is_write & sel_rom);
        if (instr_q) begin
            cause_calc = 4'd1;
        end else if (is_write) begin
            cause_calc = 4'd7;
        end else begin
            cause_calc = 4'd5;
        end
    end

    always_comb begin
        state_d = state_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        cause_d = cause_q;
        faddr_d = faddr_q;
`ifdef PMA_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (up_valid) begin
                    wstrb_d = up_wstrb;
                    addr_d  = up_addr;
                    wdata_d = up_wdata;
                    instr_d = is_instruction;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_fault) begin
                    cause_d = cause_calc;
                    faddr_d = addr_q;
                    state_d = S_FAULT;
                end else begin
`ifdef PMA_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A completion in the expiry cycle still counts as success.
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
`ifdef PMA_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    cause_d = cause_calc;
                    faddr_d = addr_q;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                // Hold off until the MMU retracts the trapped request.
                if (!up_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
            cause_q <= '0;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
        end
    end

`ifdef PMA_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    logic issuing;
    assign issuing = (state_q == S_ISSUE);

    assign mem_valid     = issuing;
    assign mem_addr      = issuing ? addr_q[31:0] : 32'd0;
    assign mem_wstrb     = issuing ? wstrb_q : 4'd0;
    assign mem_wdata     = issuing ? wdata_q : 32'd0;
    assign up_ready      = (state_q == S_RESP);
    assign up_rdata      = rdata_q;
    assign access_fault  = (state_q == S_FAULT);
    assign fault_cause   = cause_q;
    assign fault_address = faddr_q;

endmodule
